dcache_data_ram: RTL and testbench

//   Data array of the L1 data cache: dual-port word RAM with per-byte write enables.

---
 rtl/dcache_data_ram.sv | 63 ++++++
 tb/tb_dcache_data_ram.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dcache_data_ram.sv
// dcache_data_ram: L1 data-cache data array, dual-port 32-bit word RAM with per-byte write enables.
// Port A serves CPU load/store hits. Port B serves line refill and write-back reads.
// Reads are combinational (0-cycle). Writes happen on the rising edge of aclk. There is no handshake
// and no stall; the caller holds addresses stable around the edge.
// Ports: aclk/aresetn (async active-low; it gates writes and zeroes dout), enb (selects port B for
//   dout and enables port B writes), wea/ada/dina (port A), web/adb/dinb (port B), dout (read data).
// Optional feature: define DCRAM_WR_BYPASS_EN for write-first bypass of incoming write data onto dout.
module dcache_data_ram #(
  parameter int IDX_W = 7,
  parameter int OFS_W = 4,
  parameter int AW    = IDX_W + OFS_W
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          enb,
  input  logic [3:0]    wea,
  input  logic [3:0]    web,
  input  logic [AW-1:0] ada,
  input  logic [AW-1:0] adb,
  input  logic [31:0]   dina,
  input  logic [31:0]   dinb,
  output logic [31:0]   dout
);

  localparam int DEPTH = 1 << AW;

  // Reset does not clear the array. The array is left out of any reset so it maps onto plain RAM.
  logic [31:0] mem [DEPTH];

  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_word;

  // Port B's byte update is issued after port A's, so when both ports hit the same byte of the
  // same word, port B's value wins. Bytes that only port A writes still land.
  always_ff @(posedge aclk) begin
    if (aresetn) begin
      for (int i = 0; i < 4; i++) begin
        if (wea[i]) mem[ada][8*i +: 8] <= dina[8*i +: 8];
        if (enb && web[i]) mem[adb][8*i +: 8] <= dinb[8*i +: 8];
      end
    end
  end

  assign rd_addr = enb ? adb : ada;

  always_comb begin
    rd_word = mem[rd_addr];
`ifdef DCRAM_WR_BYPASS_EN
    // Write-first: a byte written this cycle at the selected address shows the incoming data.
    // Port B has priority, which matches the merge rule used for the array write.
    // When enb=1 the selected address is adb, so a port B write always targets it.
    for (int i = 0; i < 4; i++) begin
      if (enb && web[i]) begin
        rd_word[8*i +: 8] = dinb[8*i +: 8];
      end else if (wea[i] && (ada == rd_addr)) begin
        rd_word[8*i +: 8] = dina[8*i +: 8];
      end
    end
`endif
    dout = aresetn ? rd_word : 32'h0;
  end

endmodule

// File: tb/tb_dcache_data_ram.sv
module tb_dcache_data_ram;

  localparam int AW    = 11;
  localparam int DEPTH = 1 << AW;

  logic          aclk;
  logic          aresetn;
  logic          enb;
  logic [3:0]    wea;
  logic [3:0]    web;
  logic [AW-1:0] ada;
  logic [AW-1:0] adb;
  logic [31:0]   dina;
  logic [31:0]   dinb;
  logic [31:0]   dout;

  int n_checks = 0;
  int n_errors = 0;

  // Reference contents: one 32-bit word per address.
  logic [31:0] model [DEPTH];

  dcache_data_ram #(.IDX_W(7), .OFS_W(4)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .enb     (enb),
    .wea     (wea),
    .web     (web),
    .ada     (ada),
    .adb     (adb),
    .dina    (dina),
    .dinb    (dinb),
    .dout    (dout)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Apply a byte-enabled write to a word.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                        input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // Expected dout from the current inputs, before the next edge.
  function automatic logic [31:0] exp_dout();
    logic [AW-1:0] a;
    logic [31:0]   v;
    if (!aresetn) return 32'h0;
    a = enb ? adb : ada;
    v = model[a];
`ifdef DCRAM_WR_BYPASS_EN
    if (ada == a) v = merge(v, wea, dina);
    if (enb)      v = merge(v, web, dinb);
`endif
    return v;
  endfunction

  // Check dout before the edge, clock once, then update the model as the spec's write rules say.
  task automatic cyc(input string tag);
    #1 chk(tag, dout, exp_dout());
    @(posedge aclk);
    if (aresetn) begin
      model[ada] = merge(model[ada], wea, dina);
      if (enb) model[adb] = merge(model[adb], web, dinb);
    end
    #1;
  endtask

  task automatic idle();
    wea = 4'h0; web = 4'h0; enb = 1'b0;
  endtask

  task automatic write_a(input logic [AW-1:0] a, input logic [31:0] d);
    idle(); ada = a; dina = d; wea = 4'hF;
    cyc("write_a");
    idle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    aresetn = 1'b0; enb = 1'b0; wea = 4'h0; web = 4'h0;
    ada = '0; adb = '0; dina = '0; dinb = '0;
    repeat (2) @(posedge aclk);
    #1 chk("reset_dout_zero", dout, 32'h0);
    aresetn = 1'b1;

    // Give every word a known value so every read can be checked.
    for (int k = 0; k < DEPTH; k++) begin
      ada = AW'(k); dina = $urandom; wea = 4'hF;
      @(posedge aclk);
      model[k] = dina;
      #1;
    end
    idle();
    ada = '0;
    #1 chk("fill_word0", dout, model[0]);

    // Reset suppresses writes and forces dout low. The array keeps its contents.
    aresetn = 1'b0; wea = 4'hF; ada = '0; dina = 32'hDEADBEEF;
    #1 chk("reset_dout", dout, 32'h0);
    @(posedge aclk); #1;
    chk("reset_dout_after_edge", dout, 32'h0);
    aresetn = 1'b1; idle();
    #1 chk("reset_mem0_kept", dout, model[0]);

    // Port A byte write.
    write_a(11'h012, 32'h11223344);
    ada = 11'h012; dina = 32'hAABBCCDD; wea = 4'b0101;
    cyc("byte_write_cycle");
    idle(); ada = 11'h012;
    #1 chk("byte_write", dout, 32'h11BB33DD);

    // Refill of line 3 through port B.
    enb = 1'b1; web = 4'hF;
    for (int k = 0; k < 16; k++) begin
      adb = {7'd3, 4'(k)}; dinb = 32'h100 + k;
      cyc("refill_beat");
    end
    idle();
    for (int k = 0; k < 16; k++) begin
      ada = 11'h030 + 11'(k);
      #1 chk("refill_read", dout, 32'h100 + k);
    end

    // Output steering.
    write_a(11'h005, 32'hA5A5A5A5);
    write_a(11'h7F0, 32'h5A5A5A5A);
    ada = 11'h005; adb = 11'h7F0; enb = 1'b0;
    #1 chk("steer_a", dout, 32'hA5A5A5A5);
    enb = 1'b1;
    #1 chk("steer_b", dout, 32'h5A5A5A5A);
    enb = 1'b0;
    // web is ignored while enb=0.
    adb = 11'h7F0; web = 4'hF; dinb = 32'h0BADF00D; ada = 11'h005;
    cyc("web_ignored_cycle");
    idle(); ada = 11'h7F0;
    #1 chk("web_ignored", dout, 32'h5A5A5A5A);

    // Collision on the same word: port B wins where web=1.
    ada = 11'h020; adb = 11'h020; wea = 4'hF; dina = 32'h11111111;
    web = 4'b0011; dinb = 32'h22222222; enb = 1'b1;
    cyc("collision_cycle");
    idle(); ada = 11'h020;
    #1 chk("collision", dout, 32'h11112222);

    // Bypass: the value shown before the edge depends on the build option.
    write_a(11'h040, 32'h01020304);
    ada = 11'h040; wea = 4'hF; dina = 32'hCAFEF00D; enb = 1'b0;
`ifdef DCRAM_WR_BYPASS_EN
    #1 chk("bypass_pre_edge", dout, 32'hCAFEF00D);
`else
    #1 chk("bypass_pre_edge", dout, 32'h01020304);
`endif
    cyc("bypass_cycle");
    idle();
    #1 chk("bypass_post_edge", dout, 32'hCAFEF00D);

    // Random traffic with frequent address collisions.
    for (int n = 0; n < 400; n++) begin
      enb  = 1'($urandom);
      wea  = 4'($urandom);
      web  = 4'($urandom);
      dina = $urandom;
      dinb = $urandom;
      ada  = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      adb  = ($urandom_range(0, 2) == 0) ? ada : AW'($urandom_range(0, 15));
      cyc("random");
    end
    idle();
    for (int k = 0; k < 16; k++) begin
      ada = AW'(k);
      #1 chk("random_final", dout, model[k]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
